// File: rtl/prng_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// prng_pkg -- shared definitions for the PRNG arbiter slice.
//   LFSR_W        : width of the random generator (8 bits)
//   LFSR_TAP_MASK : state bits XORed into the new MSB (taps 8,6,5,4)
//   lfsr_next()   : one Fibonacci LFSR step, shift right, feedback into MSB
//   state_t       : controller states (WARM discards values, RUN grants)
// ---------------------------------------------------------------------------
package prng_pkg;

  localparam int LFSR_W = 8;

  // Feedback = s[4]^s[3]^s[2]^s[0]; maximal length (255), never reaches zero.
  localparam logic [LFSR_W-1:0] LFSR_TAP_MASK = 8'h1D;

  typedef enum logic {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAP_MASK), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/prng_arbiter_if.sv
// ---------------------------------------------------------------------------
// prng_arbiter_if -- request/grant bus of the PRNG arbiter.
//   req        : per-requester request, held until the grant is seen
//   gnt        : one-hot (or zero) grant pulse
//   rnd_data   : random byte delivered with each grant
//   busy       : high while the arbiter is warming up
//   seed_valid, seed_in, seed_err : reseed port, only with
//                                   PRNG_ARBITER_RESEED_EN defined
// Modports: slave (arbiter side), master (requester side).
// ---------------------------------------------------------------------------
interface prng_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import prng_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [LFSR_W-1:0]  rnd_data;
  logic               busy;

`ifdef PRNG_ARBITER_RESEED_EN
  logic               seed_valid;
  logic [LFSR_W-1:0]  seed_in;
  logic               seed_err;

  modport slave  (input  req, seed_valid, seed_in,
                  output gnt, rnd_data, busy, seed_err);
  modport master (output req, seed_valid, seed_in,
                  input  gnt, rnd_data, busy, seed_err);
`else
  modport slave  (input  req,
                  output gnt, rnd_data, busy);
  modport master (output req,
                  input  gnt, rnd_data, busy);
`endif

endinterface

// File: rtl/prng_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter -- combinational round-robin picker.
//   N    : number of requesters
//   req  : eligible request vector
//   last : index of the previous winner; search starts at last+1 (mod N)
//   gnt  : one-hot winner, zero when req is zero
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt
);

  localparam int PW = $clog2(N);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(last) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prng_arbiter.sv
// ---------------------------------------------------------------------------
// prng_arbiter -- round-robin arbiter that hands out one LFSR byte per grant.
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : prng_arbiter_if.slave (req in; gnt, rnd_data, busy out)
// Parameters: NUM_REQ (2..8), SEED (nonzero reset load), WARMUP (0..255
// LFSR steps discarded after each load).
// Optional feature: define PRNG_ARBITER_RESEED_EN to add the reseed port
// (seed_valid/seed_in/seed_err); otherwise the LFSR loads only on reset.
// ---------------------------------------------------------------------------
module prng_arbiter
  import prng_pkg::*;
#(
  parameter int                NUM_REQ = 4,
  parameter logic [LFSR_W-1:0] SEED    = 8'h01,
  parameter int                WARMUP  = 8
) (
  input  logic           clk,
  input  logic           resetn,
  prng_arbiter_if.slave  bus
);

  localparam int       PW         = $clog2(NUM_REQ);
  localparam logic [7:0] WARM_STEPS = 8'(WARMUP);

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [LFSR_W-1:0]   rnd_q, rnd_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  elig, win;
  logic [PW-1:0]       win_idx;
`ifdef PRNG_ARBITER_RESEED_EN
  logic                seed_err_q, seed_err_d;
`endif

  // A requester granted this cycle still has req high; mask it so it
  // cannot win twice back to back.
  assign elig = bus.req & ~gnt_q;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req  (elig),
    .last (ptr_q),
    .gnt  (win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) win_idx = PW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    rnd_d   = rnd_q;
    ptr_d   = ptr_q;
`ifdef PRNG_ARBITER_RESEED_EN
    seed_err_d = 1'b0;
`endif

    case (state_q)
      ST_WARM: begin
        if (WARM_STEPS == 8'd0) begin
          state_d = ST_RUN;
        end else begin
          // Leave WARM on the edge that takes the last discarded step.
          lfsr_d = lfsr_next(lfsr_q);
          cnt_d  = cnt_q + 8'd1;
          if (cnt_d == WARM_STEPS) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // LFSR advances only when a value is consumed.
        if (|elig) begin
          gnt_d  = win;
          rnd_d  = lfsr_q;
          lfsr_d = lfsr_next(lfsr_q);
          ptr_d  = win_idx;
        end
      end
    endcase

`ifdef PRNG_ARBITER_RESEED_EN
    // Reseed overrides whatever the FSM decided on this edge.
    if (bus.seed_valid) begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      cnt_d   = cnt_q;
      gnt_d   = '0;
      rnd_d   = rnd_q;
      ptr_d   = ptr_q;
      if (bus.seed_in != '0) begin
        lfsr_d  = bus.seed_in;
        state_d = ST_WARM;
        cnt_d   = 8'd0;
      end else begin
        seed_err_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_WARM;
      lfsr_q  <= SEED;
      cnt_q   <= 8'd0;
      gnt_q   <= '0;
      rnd_q   <= '0;
      ptr_q   <= PW'(NUM_REQ - 1);
`ifdef PRNG_ARBITER_RESEED_EN
      seed_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
      ptr_q   <= ptr_d;
`ifdef PRNG_ARBITER_RESEED_EN
      seed_err_q <= seed_err_d;
`endif
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rnd_data = rnd_q;
  assign bus.busy     = (state_q != ST_RUN);
`ifdef PRNG_ARBITER_RESEED_EN
  assign bus.seed_err = seed_err_q;
`endif

endmodule
